// File: rtl/ceps_delta.sv
// MFCC delta stage: keeps the last five cepstral frames and streams the centre
// frame's static coefficients with their first-order deltas, one per cycle.
module ceps_delta #(
    parameter int NUM_CEPS    = 12,
    parameter int CEPS_WIDTH  = 16,
    parameter int DELTA_WIDTH = 16,
    parameter int RECIP_Q16   = 6554
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear_i,
    input  logic                        in_valid,
    input  logic [$clog2(NUM_CEPS)-1:0] frame_ptr_i,
    input  logic [CEPS_WIDTH-1:0]       ceps_in,
    input  logic                        start_i,
    output logic                        out_valid_o,
    output logic [$clog2(NUM_CEPS)-1:0] out_ptr_o,
    output logic [CEPS_WIDTH-1:0]       static_o,
    output logic [DELTA_WIDTH-1:0]      delta_o,
    output logic                        done_o,
    output logic                        busy_o,
    output logic                        overrun_o
);

    localparam int PTR_W  = $clog2(NUM_CEPS);
    localparam int NUM_W  = CEPS_WIDTH + 3;
    localparam int PROD_W = NUM_W + 17;
    localparam int SLOTS  = 5;

    localparam logic [PTR_W-1:0]         LAST_K = PTR_W'(NUM_CEPS - 1);
    localparam logic signed [PROD_W-1:0] RECIP  = PROD_W'(RECIP_Q16);
    localparam logic signed [PROD_W-1:0] D_MAX  = PROD_W'((2 ** (DELTA_WIDTH - 1)) - 1);
    localparam logic signed [PROD_W-1:0] D_MIN  = ~D_MAX;

    typedef enum logic {ST_IDLE, ST_COMPUTE} state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  rd_k_q, rd_k_d;
    logic [2:0]        wr_slot_q, wr_slot_d;
    logic [2:0]        frames_q, frames_d;
    logic [2:0]        base_q, base_d;

    logic signed [CEPS_WIDTH-1:0] hist_q [SLOTS][NUM_CEPS];

    logic                         pipe_v_q;
    logic [PTR_W-1:0]             pipe_k_q;
    logic signed [CEPS_WIDTH-1:0] pipe_static_q;
    logic signed [NUM_W-1:0]      num_q;

    logic                   out_valid_q, done_q, busy_q, overrun_q;
    logic [PTR_W-1:0]       out_ptr_q;
    logic [CEPS_WIDTH-1:0]  static_q;
    logic [DELTA_WIDTH-1:0] delta_q;

    logic                         idle_ready, wr_en, commit, ovr_set, rd_valid;
    logic [2:0]                   s0, s1, s2, s3, s4;
    logic signed [NUM_W-1:0]      e0, e1, e3, e4, num_d;
    logic signed [CEPS_WIDTH-1:0] static_d;
    logic signed [PROD_W-1:0]     num_ext, prod, shifted;
    logic [DELTA_WIDTH-1:0]       delta_d;

    // Slot n frames before the just-committed one, modulo the ring size.
    function automatic logic [2:0] slot_back(input logic [2:0] base, input logic [2:0] n);
        return (base >= n) ? base - n : base + 3'd5 - n;
    endfunction

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rd_k_q    <= '0;
            wr_slot_q <= '0;
            frames_q  <= '0;
            base_q    <= '0;
        end else begin
            state_q   <= state_d;
            rd_k_q    <= rd_k_d;
            wr_slot_q <= wr_slot_d;
            frames_q  <= frames_d;
            base_q    <= base_d;
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        rd_k_d    = rd_k_q;
        wr_slot_d = wr_slot_q;
        frames_d  = frames_q;
        base_d    = base_q;
        if (clear_i) begin
            state_d   = ST_IDLE;
            rd_k_d    = '0;
            wr_slot_d = '0;
            frames_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (commit) begin
                        wr_slot_d = (wr_slot_q == 3'd4) ? 3'd0 : wr_slot_q + 3'd1;
                        frames_d  = (frames_q == 3'd5) ? 3'd5 : frames_q + 3'd1;
                        base_d    = wr_slot_q;
                        if (frames_d == 3'd5) begin
                            state_d = ST_COMPUTE;
                            rd_k_d  = '0;
                        end
                    end
                end
                ST_COMPUTE: begin
                    rd_k_d = rd_k_q + 1'b1;
                    if (rd_k_q == LAST_K) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Inputs are only taken once the previous burst has fully drained.
    always_comb begin
        idle_ready = (state_q == ST_IDLE) && !busy_q;
        wr_en      = idle_ready && !clear_i && in_valid && (frame_ptr_i <= LAST_K);
        commit     = idle_ready && !clear_i && start_i;
        ovr_set    = !idle_ready && (in_valid || start_i);
        rd_valid   = (state_q == ST_COMPUTE);
        s0 = base_q;
        s1 = slot_back(base_q, 3'd1);
        s2 = slot_back(base_q, 3'd2);
        s3 = slot_back(base_q, 3'd3);
        s4 = slot_back(base_q, 3'd4);
        e0 = hist_q[s0][rd_k_q];
        e1 = hist_q[s1][rd_k_q];
        e3 = hist_q[s3][rd_k_q];
        e4 = hist_q[s4][rd_k_q];
        static_d = hist_q[s2][rd_k_q];
        num_d = ((e0 - e4) <<< 1) + (e1 - e3);
    end

    // Division by 10 as a Q0.16 multiply; the arithmetic shift floors toward -inf.
    always_comb begin
        num_ext = num_q;
        prod    = num_ext * RECIP;
        shifted = prod >>> 16;
        if (shifted > D_MAX)      delta_d = D_MAX[DELTA_WIDTH-1:0];
        else if (shifted < D_MIN) delta_d = D_MIN[DELTA_WIDTH-1:0];
        else                      delta_d = shifted[DELTA_WIDTH-1:0];
    end

    // NOTE: the history RAM has no reset; warm-up gating means stale contents are never output.
    always_ff @(posedge clk) begin
        if (wr_en) hist_q[wr_slot_q][frame_ptr_i] <= ceps_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_v_q      <= 1'b0;
            pipe_k_q      <= '0;
            pipe_static_q <= '0;
            num_q         <= '0;
            out_valid_q   <= 1'b0;
            out_ptr_q     <= '0;
            static_q      <= '0;
            delta_q       <= '0;
            done_q        <= 1'b0;
            busy_q        <= 1'b0;
            overrun_q     <= 1'b0;
        end else if (clear_i) begin
            pipe_v_q    <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            pipe_v_q <= rd_valid;
            if (rd_valid) begin
                pipe_k_q      <= rd_k_q;
                pipe_static_q <= static_d;
                num_q         <= num_d;
            end
            out_valid_q <= pipe_v_q;
            if (pipe_v_q) begin
                out_ptr_q <= pipe_k_q;
                static_q  <= pipe_static_q;
                delta_q   <= delta_d;
            end
            done_q <= out_valid_q && (out_ptr_q == LAST_K);
            busy_q <= rd_valid || pipe_v_q;
            if (ovr_set) overrun_q <= 1'b1;
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_ptr_o   = out_ptr_q;
    assign static_o    = static_q;
    assign delta_o     = delta_q;
    assign done_o      = done_q;
    assign busy_o      = busy_q;
    assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_ceps_delta.sv
// Directed bench for ceps_delta: a default instance plus a 12-bit-delta
// instance driven from the same inputs to exercise output saturation.
module tb_ceps_delta;

    localparam int NC = 12;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        start_i = 1'b0;
    logic [3:0]  frame_ptr_i = '0;
    logic [15:0] ceps_in = '0;

    logic        out_valid_o, done_o, busy_o, overrun_o;
    logic [3:0]  out_ptr_o;
    logic [15:0] static_o, delta_o;
    logic        valid12, done12, busy12, overrun12;
    logic [3:0]  ptr12;
    logic [15:0] static12;
    logic [11:0] delta12;

    ceps_delta dut (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .in_valid(in_valid),
        .frame_ptr_i(frame_ptr_i), .ceps_in(ceps_in), .start_i(start_i),
        .out_valid_o(out_valid_o), .out_ptr_o(out_ptr_o), .static_o(static_o),
        .delta_o(delta_o), .done_o(done_o), .busy_o(busy_o), .overrun_o(overrun_o)
    );

    ceps_delta #(.DELTA_WIDTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .clear_i(clear_i), .in_valid(in_valid),
        .frame_ptr_i(frame_ptr_i), .ceps_in(ceps_in), .start_i(start_i),
        .out_valid_o(valid12), .out_ptr_o(ptr12), .static_o(static12),
        .delta_o(delta12), .done_o(done12), .busy_o(busy12), .overrun_o(overrun12)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass = 0;
    int n_valid = 0;
    int n_done = 0;
    int frame_buf [NC];
    int exp_s [NC];
    int exp_d [NC];
    int exp_d12 [NC];
    int inject_at = -1;
    int reset_at = -1;
    int snap_valid, snap_done;

    always @(negedge clk) begin
        if (out_valid_o) n_valid++;
        if (done_o) n_done++;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic fill_const(input int v);
        for (int k = 0; k < NC; k++) frame_buf[k] = v;
    endtask

    task automatic set_exp(input int s_base, input int s_step, input int d);
        for (int k = 0; k < NC; k++) begin
            exp_s[k]   = s_base + s_step * k;
            exp_d[k]   = d;
            exp_d12[k] = d;
        end
    endtask

    // One out-of-range write, then the 12 coefficients with start_i on the last.
    task automatic send_frame();
        @(negedge clk);
        in_valid = 1'b1; frame_ptr_i = 4'(NC + 1); ceps_in = 16'd9999;
        for (int k = 0; k < NC; k++) begin
            @(negedge clk);
            frame_ptr_i = 4'(k);
            ceps_in     = 16'(frame_buf[k]);
            start_i     = (k == NC - 1);
        end
        @(negedge clk);
        in_valid = 1'b0; start_i = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk); clear_i = 1'b1;
        @(negedge clk); clear_i = 1'b0;
        check("clear valid", int'(out_valid_o), 0);
        check("clear busy", int'(busy_o), 0);
        check("clear overrun", int'(overrun_o), 0);
    endtask

    // Entered on the negedge after the edge that sampled start_i.
    task automatic check_burst(input string tag);
        check({tag, " busy T"}, int'(busy_o), 0);
        check({tag, " valid T"}, int'(out_valid_o), 0);
        @(negedge clk);
        check({tag, " busy T+1"}, int'(busy_o), 1);
        check({tag, " valid T+1"}, int'(out_valid_o), 0);
        for (int k = 0; k < NC; k++) begin
            @(negedge clk);
            in_valid = 1'b0; start_i = 1'b0;
            check($sformatf("%s k%0d valid", tag, k), int'(out_valid_o), 1);
            check($sformatf("%s k%0d ptr", tag, k), int'(out_ptr_o), k);
            check($sformatf("%s k%0d static", tag, k), int'($signed(static_o)), exp_s[k]);
            check($sformatf("%s k%0d delta", tag, k), int'($signed(delta_o)), exp_d[k]);
            check($sformatf("%s k%0d delta12", tag, k), int'($signed(delta12)), exp_d12[k]);
            check($sformatf("%s k%0d busy", tag, k), int'(busy_o), 1);
            check($sformatf("%s k%0d ptr12", tag, k), int'(ptr12) + int'(valid12), k + 1);
            if (k == reset_at) begin
                rst_n = 1'b0;
                #1;
                check({tag, " rst valid"}, int'(out_valid_o), 0);
                check({tag, " rst ptr"}, int'(out_ptr_o), 0);
                check({tag, " rst static"}, int'(static_o), 0);
                check({tag, " rst delta"}, int'(delta_o), 0);
                check({tag, " rst done"}, int'(done_o), 0);
                check({tag, " rst busy"}, int'(busy_o), 0);
                return;
            end
            if (k == inject_at) begin
                in_valid = 1'b1; start_i = 1'b1; frame_ptr_i = 4'd11; ceps_in = 16'd7000;
            end
        end
        @(negedge clk);
        check({tag, " done"}, int'(done_o), 1);
        check({tag, " done12"}, int'(done12), 1);
        check({tag, " valid after"}, int'(out_valid_o), 0);
        check({tag, " busy after"}, int'(busy_o), 0);
        check({tag, " static hold"}, int'($signed(static_o)), exp_s[NC-1]);
        @(negedge clk);
        check({tag, " done pulse"}, int'(done_o), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected bench completion");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("reset valid", int'(out_valid_o), 0);
        check("reset ptr", int'(out_ptr_o), 0);
        check("reset static", int'(static_o), 0);
        check("reset delta", int'(delta_o), 0);
        check("reset done", int'(done_o), 0);
        check("reset busy", int'(busy_o), 0);
        check("reset overrun", int'(overrun_o), 0);
        rst_n = 1'b1;

        // Warm-up with a ramp c[f][k] = 10f+k: first four frames produce nothing.
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NC; k++) frame_buf[k] = 10 * f + k;
            send_frame();
        end
        repeat (16) @(negedge clk);
        check("warmup valid count", n_valid, 0);
        check("warmup done count", n_done, 0);
        for (int k = 0; k < NC; k++) frame_buf[k] = 40 + k;
        set_exp(20, 1, 10);
        send_frame();
        check_burst("ramp f4");
        for (int k = 0; k < NC; k++) frame_buf[k] = 50 + k;
        set_exp(30, 1, 10);
        send_frame();
        check_burst("ramp f5");

        // Constant frames after clear: history restarts from zero frames.
        do_clear();
        snap_valid = n_valid;
        fill_const(100);
        repeat (4) send_frame();
        repeat (16) @(negedge clk);
        check("post-clear warmup", n_valid, snap_valid);
        set_exp(100, 0, 0);
        send_frame();
        check_burst("const");
        check("overrun before", int'(overrun_o), 0);

        // Mid-burst start/write is dropped; later frames still line up.
        fill_const(200);
        set_exp(100, 0, 20);
        inject_at = 5;
        send_frame();
        check_burst("overrun");
        inject_at = -1;
        check("overrun set", int'(overrun_o), 1);
        check("overrun12 set", int'(overrun12), 1);
        fill_const(300);
        set_exp(100, 0, 50);
        send_frame();
        check_burst("wrap 300");
        fill_const(400);
        set_exp(200, 0, 80);
        send_frame();
        check_burst("wrap 400");
        check("overrun sticky", int'(overrun_o), 1);

        // Floor rounding: num = -(1+k).
        do_clear();
        fill_const(5); send_frame();
        for (int k = 0; k < NC; k++) frame_buf[k] = 6 + k;
        send_frame();
        for (int k = 0; k < NC; k++) frame_buf[k] = k;
        send_frame();
        fill_const(5); send_frame();
        set_exp(0, 1, -1);
        for (int k = 9; k < NC; k++) begin
            exp_d[k] = -2;
            exp_d12[k] = -2;
        end
        send_frame();
        check_burst("floor");

        // Saturation: even k num=+196605, odd k num=-196605.
        do_clear();
        for (int f = 0; f < 5; f++) begin
            for (int k = 0; k < NC; k++) begin
                if (f == 2) frame_buf[k] = 0;
                else if (f < 2) frame_buf[k] = (k % 2 == 0) ? -32768 : 32767;
                else frame_buf[k] = (k % 2 == 0) ? 32767 : -32768;
            end
            if (f == 4) begin
                for (int k = 0; k < NC; k++) begin
                    exp_s[k]   = 0;
                    exp_d[k]   = (k % 2 == 0) ? 19661 : -19662;
                    exp_d12[k] = (k % 2 == 0) ? 2047 : -2048;
                end
            end
            send_frame();
        end
        check_burst("sat");

        // Reset at the sixth output of a burst.
        for (int k = 0; k < NC; k++) begin
            frame_buf[k] = (k % 2 == 0) ? -32768 : 32767;
            exp_s[k]     = (k % 2 == 0) ? 32767 : -32768;
            exp_d[k]     = (k % 2 == 0) ? 3276 : -3277;
            exp_d12[k]   = (k % 2 == 0) ? 2047 : -2048;
        end
        reset_at = 5;
        send_frame();
        check_burst("reset");
        reset_at = -1;
        snap_valid = n_valid;
        snap_done = n_done;
        @(negedge clk); rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("reset no done", n_done, snap_done);
        check("reset no valid", n_valid, snap_valid);
        fill_const(100);
        repeat (4) send_frame();
        repeat (16) @(negedge clk);
        check("post-reset warmup", n_valid, snap_valid);
        set_exp(100, 0, 0);
        send_frame();
        check_burst("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
